key_note_encoder: RTL and testbench

//  Upstream stage of the sine/PWM tone generator. Conditions the 16 TinyFPGA BX key pins
//  (PIN_8..13, PIN_15..24) and selects one note, last-pressed priority. Emits the 32-bit DDS

---
 rtl/synth_pkg.sv | 27 ++
 rtl/key_debounce.sv | 57 +++++
 rtl/key_note_encoder.sv | 95 +++++++++
 tb/tb_key_note_encoder.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// rtl/synth_pkg.sv - shared tone-generator constants: note step table and widths
package synth_pkg;

  localparam int KEY_COUNT = 16;
  localparam int IDX_W     = 4;
  localparam int STEP_W    = 32;
  localparam int SAMPLE_HZ = 16000000;

  // DDS phase increments for a 16 MHz accumulator, key k = 440*2^(k/12) Hz
  localparam logic [STEP_W-1:0] NOTE_STEP [0:KEY_COUNT-1] = '{
    32'd118112, 32'd125135, 32'd132576, 32'd140459,
    32'd148811, 32'd157660, 32'd167035, 32'd176967,
    32'd187490, 32'd198639, 32'd210451, 32'd222965,
    32'd236223, 32'd250270, 32'd265152, 32'd280918
  };

  // Index of the lowest set bit; 0 when no bit is set
  function automatic logic [IDX_W-1:0] lowest_index(input logic [KEY_COUNT-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = KEY_COUNT - 1; i >= 0; i--) begin
      if (v[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - per-key synchroniser, tick-based debounce and press/release pulses
module key_debounce #(
  parameter int ACTIVE_LOW     = 1,
  parameter int DEBOUNCE_TICKS = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic tick,
  input  logic key_raw,
  output logic stable,
  output logic press_evt,
  output logic release_evt
);

  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);
  // Pin level of a released key, so the synchroniser comes out of reset idle
  localparam logic IDLE_LEVEL = (ACTIVE_LOW != 0);

  logic          sync1;
  logic          sync2;
  logic          pressed;
  logic [CW-1:0] cnt;

  assign pressed = (ACTIVE_LOW != 0) ? ~sync2 : sync2;

  // Synchronise the pin, count ticks of disagreement and flip the stable state
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1       <= IDLE_LEVEL;
      sync2       <= IDLE_LEVEL;
      stable      <= 1'b0;
      cnt         <= '0;
      press_evt   <= 1'b0;
      release_evt <= 1'b0;
    end else begin
      sync1       <= key_raw;
      sync2       <= sync1;
      press_evt   <= 1'b0;
      release_evt <= 1'b0;
      if (pressed == stable) begin
        cnt <= '0;
      end else if (tick) begin
        // >= keeps the counter bounded even if it were ever past the limit
        if (cnt >= CNT_LAST) begin
          stable      <= ~stable;
          cnt         <= '0;
          press_evt   <= ~stable;
          release_evt <= stable;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/key_note_encoder.sv
// rtl/key_note_encoder.sv - debounced keys to last-pressed note and DDS phase increment
module key_note_encoder #(
  parameter int NUM_KEYS       = 16,
  parameter int ACTIVE_LOW     = 1,
  parameter int TICK_DIV       = 16000,
  parameter int DEBOUNCE_TICKS = 8,
  parameter int STEP_W         = 32
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [NUM_KEYS-1:0]         keys_raw,
  output logic [STEP_W-1:0]           freq_step,
  output logic [$clog2(NUM_KEYS)-1:0] note_idx,
  output logic                        gate,
  output logic                        step_valid
);

  import synth_pkg::*;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0]       presc;
  logic                tick;
  logic [NUM_KEYS-1:0] stable_vec;
  logic [NUM_KEYS-1:0] press_vec;
  logic [NUM_KEYS-1:0] release_vec;
  logic [IDX_W-1:0]    nxt_note;
  logic                nxt_gate;
  logic                changed;

  // Debounce tick prescaler shared by all keys
  always_ff @(posedge CLK) begin
    if (RST) begin
      presc <= '0;
    end else if (presc == TICK_LAST) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  assign tick = (presc == TICK_LAST);

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce #(
      .ACTIVE_LOW     (ACTIVE_LOW),
      .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
    ) u_debounce (
      .CLK         (CLK),
      .RST         (RST),
      .tick        (tick),
      .key_raw     (keys_raw[k]),
      .stable      (stable_vec[k]),
      .press_evt   (press_vec[k]),
      .release_evt (release_vec[k])
    );
  end

  // Last-pressed priority: new press wins, current release falls back to lowest held key
  always_comb begin
    nxt_note = note_idx;
    nxt_gate = gate;
    if (|press_vec) begin
      nxt_note = lowest_index(KEY_COUNT'(press_vec));
      nxt_gate = 1'b1;
    end else if (gate && release_vec[note_idx]) begin
      if (|stable_vec) begin
        nxt_note = lowest_index(KEY_COUNT'(stable_vec));
      end else begin
        nxt_gate = 1'b0;
      end
    end
  end

  assign changed = (nxt_note != note_idx) || (nxt_gate != gate);

  // Output registers; freq_step only reloads on a change so it stays 0 out of reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      freq_step  <= '0;
      note_idx   <= '0;
      gate       <= 1'b0;
      step_valid <= 1'b0;
    end else begin
      step_valid <= changed;
      if (changed) begin
        freq_step <= STEP_W'(NOTE_STEP[nxt_note]);
        note_idx  <= nxt_note;
        gate      <= nxt_gate;
      end
    end
  end

endmodule

// File: tb/tb_key_note_encoder.sv
// tb/tb_key_note_encoder.sv - directed scoreboard bench for key_note_encoder
module tb_key_note_encoder;

  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] keys_raw;
  logic [31:0] freq_step;
  logic [3:0]  note_idx;
  logic        gate;
  logic        step_valid;

  typedef struct {
    logic        gate;
    logic [3:0]  note;
    logic [31:0] step;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   lat;

  key_note_encoder #(
    .NUM_KEYS       (16),
    .ACTIVE_LOW     (1),
    .TICK_DIV       (4),
    .DEBOUNCE_TICKS (3),
    .STEP_W         (32)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .keys_raw   (keys_raw),
    .freq_step  (freq_step),
    .note_idx   (note_idx),
    .gate       (gate),
    .step_valid (step_valid)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic expect_out(input logic g, input logic [3:0] n, input logic [31:0] s);
    exp_t e;
    e.gate = g;
    e.note = n;
    e.step = s;
    exp_q.push_back(e);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic wait_drain(input string tag, input int budget, output int l);
    l = 0;
    while (exp_q.size() != 0 && l < budget) begin
      @(negedge CLK);
      #1;
      l++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  // Every step_valid pulse must match the next queued expectation
  always @(negedge CLK) begin
    if (!RST && step_valid) begin
      check("pulse_expected", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("pulse_gate", gate, e.gate);
        check("pulse_note", note_idx, e.note);
        check("pulse_step", freq_step, e.step);
      end
    end
  end

  initial begin
    RST      = 1'b1;
    keys_raw = 16'hFFFF;

    // 1: reset with idle keys
    cycles(5);
    check("rst_gate", gate, 0);
    check("rst_note", note_idx, 0);
    check("rst_step", freq_step, 0);
    check("rst_valid", step_valid, 0);
    RST = 1'b0;
    cycles(20);
    check("idle_gate", gate, 0);
    check("idle_step", freq_step, 0);

    // 2: key0 held
    expect_out(1'b1, 4'd0, 32'd118112);
    keys_raw[0] = 1'b0;
    wait_drain("drain_key0", 40, lat);
    check("key0_latency_ok", (lat <= 20), 1);
    cycles(3);
    check("key0_gate", gate, 1);
    check("key0_step", freq_step, 118112);

    // 3: key3 bouncing faster than the debounce window
    for (int i = 0; i < 16; i++) begin
      keys_raw[3] = ~keys_raw[3];
      cycles(6);
    end
    cycles(20);
    check("bounce_note", note_idx, 0);
    check("bounce_step", freq_step, 118112);
    check("bounce_gate", gate, 1);

    // 4: key7 over key0, then releases
    expect_out(1'b1, 4'd7, 32'd176967);
    keys_raw[7] = 1'b0;
    wait_drain("drain_key7_press", 40, lat);
    expect_out(1'b1, 4'd0, 32'd118112);
    keys_raw[7] = 1'b1;
    wait_drain("drain_key7_release", 40, lat);
    expect_out(1'b0, 4'd0, 32'd118112);
    keys_raw[0] = 1'b1;
    wait_drain("drain_key0_release", 40, lat);
    cycles(3);
    check("tail_gate", gate, 0);
    check("tail_step", freq_step, 118112);

    // 5: simultaneous presses, then release of the non-current key
    expect_out(1'b1, 4'd5, 32'd157660);
    keys_raw[12] = 1'b0;
    keys_raw[5]  = 1'b0;
    wait_drain("drain_dual_press", 40, lat);
    keys_raw[12] = 1'b1;
    cycles(30);
    check("noncur_note", note_idx, 5);
    check("noncur_step", freq_step, 157660);
    check("noncur_gate", gate, 1);
    expect_out(1'b0, 4'd5, 32'd157660);
    keys_raw[5] = 1'b1;
    wait_drain("drain_key5_release", 40, lat);

    // 6: reset while key12 is held
    expect_out(1'b1, 4'd12, 32'd236223);
    keys_raw[12] = 1'b0;
    wait_drain("drain_key12_press", 40, lat);
    cycles(2);
    RST = 1'b1;
    cycles(1);
    RST = 1'b0;
    check("midrst_gate", gate, 0);
    check("midrst_note", note_idx, 0);
    check("midrst_step", freq_step, 0);
    expect_out(1'b1, 4'd12, 32'd236223);
    wait_drain("drain_key12_redetect", 40, lat);
    check("redetect_full_debounce", (lat >= 10 && lat <= 20), 1);

    cycles(10);
    check("final_queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
